// File: rtl/conv_kernel_1x2x8_sched_pkg.sv
// Shared types and defaults for the 1x2x8 conv kernel sequencer.
package conv_kernel_1x2x8_sched_pkg;

    localparam int unsigned DEF_RD_LAT   = 1;
    localparam int unsigned DEF_PIPE_LAT = 6;
    localparam int unsigned DEF_CIG_W    = 8;
    localparam int unsigned DEF_PIX_W    = 16;
    localparam int unsigned DEF_COP_W    = 8;
    localparam int unsigned DEF_WA_W     = 16;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [DEF_PIX_W-1:0] pix;
        logic [DEF_COP_W-1:0] cop;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/conv_kernel_1x2x8_sched_tag_delay.sv
// Fixed-depth shift register carrying issue tags alongside the free-running kernel pipeline.
module conv_kernel_1x2x8_sched_tag_delay
    import conv_kernel_1x2x8_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_kernel_1x2x8_sched.sv
// Layer sequencer: walks (cop, pix, cig) issuing one buffer read per cycle and tags the
// kernel pipeline so the accumulator knows when to load, add and emit.
module conv_kernel_1x2x8_sched
    import conv_kernel_1x2x8_sched_pkg::*;
#(
    parameter int unsigned RD_LAT   = DEF_RD_LAT,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned CIG_W    = DEF_CIG_W,
    parameter int unsigned PIX_W    = DEF_PIX_W,
    parameter int unsigned COP_W    = DEF_COP_W,
    parameter int unsigned WA_W     = DEF_WA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CIG_W-1:0] cfg_num_cig,
    input  logic [PIX_W-1:0] cfg_num_pix,
    input  logic [COP_W-1:0] cfg_num_cop,
    input  logic             src_ready,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [CIG_W-1:0] rd_cig,
    output logic [PIX_W-1:0] rd_pix,
    output logic [WA_W-1:0]  wgt_addr,
    output logic [COP_W-1:0] bias_addr,
    output logic             bias_valid,
    output logic             ofm_valid,
    output logic             ofm_first,
    output logic             ofm_last,
    output logic [PIX_W-1:0] ofm_pix,
    output logic [COP_W-1:0] ofm_cop
);

    localparam int unsigned DRAIN_CYC = RD_LAT + PIPE_LAT;
    localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);

    state_e             state_q, state_d;
    logic [CIG_W-1:0]   num_cig_q, num_cig_d, cig_q, cig_d;
    logic [PIX_W-1:0]   num_pix_q, num_pix_d, pix_q, pix_d;
    logic [COP_W-1:0]   num_cop_q, num_cop_d, cop_q, cop_d;
    logic [WA_W-1:0]    base_q, base_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic last_cig, last_pix, last_cop;
    tag_t tag_in, bias_tap, ofm_tap;

    assign last_cig = (cig_q == num_cig_q - CIG_W'(1));
    assign last_pix = (pix_q == num_pix_q - PIX_W'(1));
    assign last_cop = (cop_q == num_cop_q - COP_W'(1));

    always_comb begin
        state_d   = state_q;
        num_cig_d = num_cig_q;
        num_pix_d = num_pix_q;
        num_cop_d = num_cop_q;
        cig_d     = cig_q;
        pix_d     = pix_q;
        cop_d     = cop_q;
        base_d    = base_q;
        drain_d   = drain_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    num_cig_d = (cfg_num_cig == '0) ? CIG_W'(1) : cfg_num_cig;
                    num_pix_d = (cfg_num_pix == '0) ? PIX_W'(1) : cfg_num_pix;
                    num_cop_d = (cfg_num_cop == '0) ? COP_W'(1) : cfg_num_cop;
                    cig_d     = '0;
                    pix_d     = '0;
                    cop_d     = '0;
                    base_d    = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (src_ready) begin
                    if (!last_cig) begin
                        cig_d = cig_q + CIG_W'(1);
                    end else begin
                        cig_d = '0;
                        if (!last_pix) begin
                            pix_d = pix_q + PIX_W'(1);
                        end else begin
                            pix_d = '0;
                            if (!last_cop) begin
                                // Running base replaces a cop*num_cig multiply.
                                cop_d  = cop_q + COP_W'(1);
                                base_d = base_q + WA_W'(num_cig_q);
                            end else begin
                                cop_d   = '0;
                                base_d  = '0;
                                drain_d = '0;
                                state_d = StDrain;
                            end
                        end
                    end
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            num_cig_q <= '0;
            num_pix_q <= '0;
            num_cop_q <= '0;
            cig_q     <= '0;
            pix_q     <= '0;
            cop_q     <= '0;
            base_q    <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            num_cig_q <= num_cig_d;
            num_pix_q <= num_pix_d;
            num_cop_q <= num_cop_d;
            cig_q     <= cig_d;
            pix_q     <= pix_d;
            cop_q     <= cop_d;
            base_q    <= base_d;
            drain_q   <= drain_d;
        end
    end

    assign rd_en     = (state_q == StRun) && src_ready;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign rd_cig    = rd_en ? cig_q : '0;
    assign rd_pix    = rd_en ? pix_q : '0;
    assign wgt_addr  = rd_en ? (base_q + WA_W'(cig_q)) : '0;
    assign bias_addr = rd_en ? cop_q : '0;

    // Bubbles enter as all-zero tags, so every delayed field is 0 whenever valid is 0.
    always_comb begin
        tag_in = '0;
        if (rd_en) begin
            tag_in.valid = 1'b1;
            tag_in.first = (cig_q == '0);
            tag_in.last  = last_cig;
            tag_in.pix   = pix_q;
            tag_in.cop   = cop_q;
        end
    end

    conv_kernel_1x2x8_sched_tag_delay #(
        .DEPTH(RD_LAT),
        .WIDTH(TAG_W)
    ) u_bias_tap (
        .clk (clk),
        .rst (rst),
        .din (tag_in),
        .dout(bias_tap)
    );

    conv_kernel_1x2x8_sched_tag_delay #(
        .DEPTH(PIPE_LAT),
        .WIDTH(TAG_W)
    ) u_ofm_tap (
        .clk (clk),
        .rst (rst),
        .din (bias_tap),
        .dout(ofm_tap)
    );

    assign bias_valid = bias_tap.valid & bias_tap.first;
    assign ofm_valid  = ofm_tap.valid;
    assign ofm_first  = ofm_tap.first;
    assign ofm_last   = ofm_tap.last;
    assign ofm_pix    = ofm_tap.pix;
    assign ofm_cop    = ofm_tap.cop;

endmodule
